// File: rtl/renode_bus_responder.sv
// renode_bus_responder
//   Register-bank target for bus transactions issued from the Renode
//   bus-controller path. One request in flight at a time: IDLE accepts and
//   decodes it, WAIT burns WaitStates cycles, RESP holds the response until it
//   is taken. Sizes are Byte/Word/DoubleWord/QuadWord (req_size 0..3).
//
//   Optional feature macro: RENODE_RESPONDER_IRQ_EN
//     When defined, the last register is a doorbell and the irq output exists.
//     A successful write that leaves the doorbell nonzero sets irq; one that
//     leaves it zero clears it. irq is a sticky registered level.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_write             1 = write, 0 = read
//   req_size              0 B, 1 W, 2 DW, 3 QW
//   req_addr              byte address (AddressWidth bits)
//   req_data              write data, right-aligned
//   rsp_valid/rsp_ready   response handshake
//   rsp_error             access rejected (range / below base / misaligned)
//   rsp_data              read data, right-aligned, zero-extended; 0 otherwise
//   irq                   doorbell interrupt (RENODE_RESPONDER_IRQ_EN only)
module renode_bus_responder #(
    parameter int unsigned                AddressWidth  = 32,
    parameter logic [AddressWidth-1:0]    BaseAddress   = '0,
    parameter int unsigned                RegisterCount = 16,
    parameter int unsigned                WaitStates    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [63:0]             req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_error,
    output logic [63:0]             rsp_data
`ifdef RENODE_RESPONDER_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int unsigned IW = (RegisterCount > 1) ? $clog2(RegisterCount) : 1;
    localparam logic [AddressWidth:0] Limit = (AddressWidth+1)'(RegisterCount * 8);
    localparam logic [5:0] WaitLoad = 6'(WaitStates - 1);
    localparam bit NoWait = (WaitStates == 0);
    localparam logic [IW-1:0] DoorbellIdx = IW'(RegisterCount - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic          write;
        logic          err;
        logic [IW-1:0] idx;
        logic [2:0]    lane;
        logic [1:0]    size;
        logic [63:0]   data;
    } req_t;

    state_t state, state_nxt;
    logic [5:0] cnt;
    req_t dec, held, cur;
    logic accept, enter_resp;
    logic [AddressWidth-1:0] off;
    logic misaligned;
    logic [63:0] regs [RegisterCount];
    logic [7:0]  bmask;
    logic [63:0] wmask, smask, wshift, merged, rdata;
    logic [5:0]  shamt;
    logic [63:0] rsp_data_q;
    logic        rsp_error_q;

    // Decode straight off the request pins; only meaningful while IDLE.
    always_comb begin
        off = req_addr - BaseAddress;
        case (req_size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            2'd3:    misaligned = |off[2:0];
            default: misaligned = 1'b0;
        endcase
        dec.write = req_write;
        dec.size  = req_size;
        dec.data  = req_data;
        dec.lane  = off[2:0];
        dec.idx   = off[IW+2:3];
        // Below-base check stops an underflowed off from aliasing into range.
        dec.err   = (req_addr < BaseAddress) || ({1'b0, off} >= Limit) || misaligned;
    end

    // With zero wait states the commit happens on the accept edge, so the
    // live decode is used directly instead of the latched copy.
    assign cur = (state == S_IDLE) ? dec : held;

    always_comb begin
        case (cur.size)
            2'd0:    begin bmask = 8'h01; smask = 64'h0000_0000_0000_00ff; end
            2'd1:    begin bmask = 8'h03; smask = 64'h0000_0000_0000_ffff; end
            2'd2:    begin bmask = 8'h0f; smask = 64'h0000_0000_ffff_ffff; end
            default: begin bmask = 8'hff; smask = '1; end
        endcase
        bmask = bmask << cur.lane;
        wmask = '0;
        for (int b = 0; b < 8; b++) wmask[b*8 +: 8] = {8{bmask[b]}};
        shamt  = {cur.lane, 3'b000};
        wshift = cur.data << shamt;
        merged = (regs[cur.idx] & ~wmask) | (wshift & wmask);
        rdata  = (regs[cur.idx] >> shamt) & smask;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: if (req_valid) begin
                accept = 1'b1;
                if (NoWait) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (cnt == 6'd0) begin
                state_nxt  = S_RESP;
                enter_resp = 1'b1;
            end
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            held        <= '0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int i = 0; i < int'(RegisterCount); i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                held <= dec;
                cnt  <= WaitLoad;
            end else if (state == S_WAIT && cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
            end
            if (enter_resp) begin
                rsp_error_q <= cur.err;
                rsp_data_q  <= (cur.err || cur.write) ? 64'd0 : rdata;
                if (!cur.err && cur.write) regs[cur.idx] <= merged;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_error_q <= 1'b0;
                rsp_data_q  <= '0;
            end
        end
    end

`ifdef RENODE_RESPONDER_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (enter_resp && !cur.err && cur.write && cur.idx == DoorbellIdx)
            irq <= |merged;
    end
`else
    logic unused_doorbell;
    assign unused_doorbell = ^DoorbellIdx;
`endif

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_error = rsp_error_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_renode_bus_responder.sv
module tb_renode_bus_responder;

    localparam int AW = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int RC = 16;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [63:0] rsp_data;
`ifdef RENODE_RESPONDER_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    renode_bus_responder #(
        .AddressWidth(AW), .BaseAddress(BASE), .RegisterCount(RC), .WaitStates(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
        .rsp_data(rsp_data)
`ifdef RENODE_RESPONDER_IRQ_EN
        , .irq(irq)
`endif
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [63:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_data = d;
    endtask

    // Issues one request with rsp_ready high; the response is checked against
    // the scoreboard entry pushed here, and latency is counted in rising
    // edges from the accept edge (inclusive) to the first rsp_valid.
    task automatic txn(input string name, input vec_t v);
        exp_t e;
        int lat;
        int guard;
        sb.push_back('{err: v.exp_err, data: v.exp_data});
        drive_req(v.wr, v.size, v.addr, v.wdata);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        check({name, " req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({name, " latency"}, 64'(lat), 64'(WS + 1));
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, " rsp_error"}, 64'(rsp_error), 64'(e.err));
            check({name, " rsp_data"}, rsp_data, e.data);
        end
        @(posedge clk); #1;
        check({name, " back to idle"}, {62'd0, rsp_valid, req_ready}, 64'b01);
    endtask

    vec_t vecs[17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] held_data;
        vec_t v;

        // wr size addr wdata err data
        vecs[0]  = '{1'b1, 2'd3, BASE + 32'h08, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 2'd3, BASE + 32'h08, 64'h0, 1'b0, 64'h1122_3344_5566_7788};
        // byte 0xB is byte 3 of reg1, the top byte of its low doubleword
        vecs[2]  = '{1'b1, 2'd0, BASE + 32'h0B, 64'hAB, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 2'd2, BASE + 32'h08, 64'h0, 1'b0, 64'h0000_0000_AB66_7788};
        vecs[4]  = '{1'b0, 2'd1, BASE + 32'h01, 64'h0, 1'b1, 64'h0};
        vecs[5]  = '{1'b0, 2'd3, BASE + 32'h80, 64'h0, 1'b1, 64'h0};
        vecs[6]  = '{1'b0, 2'd0, BASE - 32'h01, 64'h0, 1'b1, 64'h0};
        vecs[7]  = '{1'b0, 2'd3, 32'hFFFF_FFF8, 64'h0, 1'b1, 64'h0};
        vecs[8]  = '{1'b0, 2'd3, BASE + 32'h08, 64'h0, 1'b0, 64'h1122_3344_AB66_7788};
        vecs[9]  = '{1'b1, 2'd1, BASE + 32'h12, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 2'd3, BASE + 32'h10, 64'h0, 1'b0, 64'h0000_0000_BEEF_0000};
        vecs[11] = '{1'b0, 2'd1, BASE + 32'h12, 64'h0, 1'b0, 64'h0000_0000_0000_BEEF};
        vecs[12] = '{1'b0, 2'd0, BASE + 32'h13, 64'h0, 1'b0, 64'h0000_0000_0000_00BE};
        vecs[13] = '{1'b1, 2'd2, BASE + 32'h74, 64'h1234_5678_CAFE_F00D, 1'b0, 64'h0};
        vecs[14] = '{1'b0, 2'd3, BASE + 32'h70, 64'h0, 1'b0, 64'hCAFE_F00D_0000_0000};
        vecs[15] = '{1'b1, 2'd3, BASE + 32'h14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vecs[16] = '{1'b0, 2'd3, BASE + 32'h10, 64'h0, 1'b0, 64'h0000_0000_BEEF_0000};

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_error", 64'(rsp_error), 64'd0);
        check("reset rsp_data", rsp_data, 64'd0);
`ifdef RENODE_RESPONDER_IRQ_EN
        check("reset irq", 64'(irq), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 17; i++) txn($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: hold rsp_ready low in RESP; a write presented meanwhile
        // must be ignored.
        rsp_ready = 1'b0;
        drive_req(1'b0, 2'd3, BASE + 32'h08, 64'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            int g;
            g = 0;
            while (!rsp_valid && g < 100) begin @(posedge clk); #1; g++; end
        end
        check("bp rsp_valid", 64'(rsp_valid), 64'd1);
        held_data = 64'h1122_3344_AB66_7788;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
        req_addr = BASE + 32'h08; req_data = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", c), {61'd0, rsp_valid, req_ready, rsp_error}, 64'b100);
            check($sformatf("bp data%0d", c), rsp_data, held_data);
        end
        req_valid = 1'b0;
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {62'd0, rsp_valid, req_ready}, 64'b01);
        v = '{1'b0, 2'd3, BASE + 32'h08, 64'h0, 1'b0, 64'h1122_3344_AB66_7788};
        txn("bp ignored write", v);

`ifdef RENODE_RESPONDER_IRQ_EN
        v = '{1'b1, 2'd2, BASE + 32'h78, 64'h1, 1'b0, 64'h0};
        txn("doorbell set", v);
        check("irq set", 64'(irq), 64'd1);
        v = '{1'b1, 2'd3, BASE + 32'h78, 64'h0, 1'b0, 64'h0};
        txn("doorbell clr", v);
        check("irq clr", 64'(irq), 64'd0);
`endif

        // Reset during WAIT of a write: response and commit are both dropped.
        drive_req(1'b1, 2'd3, BASE + 32'h30, 64'h5A5A_5A5A_5A5A_5A5A);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid-wait no rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (WS + 2) @(posedge clk);
        #1;
        check("post-reset idle", {62'd0, rsp_valid, req_ready}, 64'b01);
        v = '{1'b0, 2'd3, BASE + 32'h30, 64'h0, 1'b0, 64'h0};
        txn("aborted write", v);
        v = '{1'b0, 2'd3, BASE + 32'h08, 64'h0, 1'b0, 64'h0};
        txn("regs cleared", v);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
